adder_rr_arbiter: RTL and testbench
===================================

Name: adder_rr_arbiter

Overview:
- Round-robin arbiter that shares one registered WIDTH-bit adder between NUM_REQ requesters.
- Each requester presents an operand pair under valid/ready. The arbiter grants one requester per cycle and returns the sum with carry and requester id through a single-entry output register with backpressure.
- Sits between the pin-level input mux and the adder result path in the top-level tile. It replaces the free-running combinational sum.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); id width IDW = clog2(NUM_REQ).
- WIDTH, 8, operand width.
- CNT_W, 16, width of the grant counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ena  input  1  grant enable; low blocks new grants, drain still allowed.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_a  input  NUM_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand B, same packing.
- req_ready  output  NUM_REQ  one-hot grant, combinational.
- rsp_valid  output  1  result register holds valid data.
- rsp_ready  input  1  consumer accepts result.
- rsp_sum  output  WIDTH  registered a+b, low WIDTH bits.
- rsp_carry  output  1  carry-out of a+b.
- rsp_id  output  IDW  index of the granted requester.
- grant_count  output  CNT_W  total grants since reset, wraps.
- busy  output  1  equals rsp_valid.

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, grant_count=0, round-robin pointer ptr=0.
- Slot free: free = !rsp_valid | rsp_ready.
- Grant condition: grant occurs iff ena & free & |req_valid.
- Grant selection: winner g = first i with req_valid[i] set, searching ptr, ptr+1, … mod NUM_REQ.
- req_ready: req_ready = onehot(g) when a grant occurs, else all zero.
- req_ready timing: req_ready is combinational from req_valid/ena/rsp_ready. Requesters must not make req_valid depend on req_ready.
- Transfer on grant, next edge: {rsp_carry,rsp_sum} <= a_g + b_g as a WIDTH+1-bit sum; rsp_id <= g; rsp_valid <= 1; ptr <= (g+1) mod NUM_REQ; grant_count <= grant_count+1.
- Latency: one cycle from handshake to rsp_valid.
- Throughput: one result per cycle when rsp_ready is held high.
- Drain without grant: if rsp_valid & rsp_ready and no grant, rsp_valid <= 0. Data registers hold their last value.
- Backpressure: if rsp_valid & !rsp_ready, no grant. All rsp_* outputs and ptr are stable. Requesters keep valid asserted and their operands unchanged.
- Simultaneous drain and grant: same cycle, result replaced, rsp_valid stays 1.
- ena low: no grants and ptr frozen. A pending result still drains normally.
- Wrap: grant_count wraps 2^CNT_W-1 -> 0. ptr wraps NUM_REQ-1 -> 0. Carry is reported, never saturated.
- Non-power-of-two NUM_REQ: ptr never takes a value >= NUM_REQ.
- Reset mid-operation: pending result is discarded and rsp_valid drops immediately. No handshake completes in the reset cycle.
- No requesters valid: req_ready=0, nothing else changes apart from a possible drain.

Test Plan:
- Reset then single request: req_valid=0001, a0=8'h12, b0=8'h34, rsp_ready=1 -> req_ready=0001 in the same cycle; next cycle rsp_valid=1, rsp_sum=8'h46, rsp_carry=0, rsp_id=0, grant_count=1.
- Carry: a=8'hFF, b=8'h02 on requester 2 -> rsp_sum=8'h01, rsp_carry=1, rsp_id=2.
- Fairness: all four valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1 on consecutive cycles; grant_count increments by 1 every cycle.
- Backpressure: rsp_ready=0 for 3 cycles with req_valid=1111 -> req_ready=0000, rsp_* stable. When rsp_ready=1, the next id is granted in the same cycle and rsp_valid stays 1.
- ena low: ena=0 with req_valid=0010 -> no grant, ptr unchanged. Raise ena -> rsp_id=1 next cycle.
- Async reset mid-stream: assert rst between clock edges while rsp_valid=1 -> rsp_valid=0, grant_count=0 immediately. After release, the first grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter
// Shares one registered WIDTH-bit adder between NUM_REQ requesters.
// A rotating priority pointer picks one requester per cycle, and the
// sum, carry and winner id land in a single-entry output register
// that honours consumer backpressure.

module adder_rr_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int WIDTH   = 8,
   parameter  int CNT_W   = 16,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ena,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WIDTH-1:0]         rsp_sum,
   output logic                     rsp_carry,
   output logic [IDW-1:0]           rsp_id,
   output logic [CNT_W-1:0]         grant_count,
   output logic                     busy
);

   // Round-robin pointer: the requester searched first on the next grant.
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   ptr_next;

   // Winner of the rotating search and its operands.
   logic             win_found;
   logic [IDW-1:0]   win_id;
   logic [WIDTH-1:0] win_a;
   logic [WIDTH-1:0] win_b;
   logic [WIDTH:0]   sum_ext;

   // The output slot can take a new result when empty or being drained.
   logic             slot_free;
   logic             grant;

   assign slot_free = !rsp_valid || rsp_ready;
   assign grant     = ena && slot_free && win_found;
   assign busy      = rsp_valid;

   // Search ptr, ptr+1, ... modulo NUM_REQ for the first valid requester.
   always_comb begin
      int idx;
      win_found = 1'b0;
      win_id    = '0;
      win_a     = '0;
      win_b     = '0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!win_found && req_valid[idx]) begin
            win_found = 1'b1;
            win_id    = IDW'(idx);
            win_a     = req_a[idx*WIDTH +: WIDTH];
            win_b     = req_b[idx*WIDTH +: WIDTH];
         end
      end
   end

   // One-hot ready for the winner only when a grant actually happens.
   always_comb begin
      req_ready = '0;
      if (grant) begin
         req_ready[win_id] = 1'b1;
      end
   end

   // Full-width sum so the carry-out is reported rather than lost, and the
   // pointer step that wraps at NUM_REQ even when it is not a power of two.
   always_comb begin
      sum_ext = {1'b0, win_a} + {1'b0, win_b};
      if (win_id == IDW'(NUM_REQ - 1)) begin
         ptr_next = '0;
      end else begin
         ptr_next = win_id + 1'b1;
      end
   end

   // Result register, pointer and grant counter; drain clears valid only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid   <= 1'b0;
         rsp_sum     <= '0;
         rsp_carry   <= 1'b0;
         rsp_id      <= '0;
         grant_count <= '0;
         ptr         <= '0;
      end else if (grant) begin
         rsp_valid   <= 1'b1;
         {rsp_carry, rsp_sum} <= sum_ext;
         rsp_id      <= win_id;
         grant_count <= grant_count + 1'b1;
         ptr         <= ptr_next;
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb_adder_rr_arbiter
// Directed scenarios for the round-robin shared adder with
// hand-computed expected results.

module tb_adder_rr_arbiter;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 8;
   localparam int CNT_W   = 16;
   localparam int IDW     = 2;

   logic                     clk;
   logic                     rst;
   logic                     ena;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [WIDTH-1:0]         rsp_sum;
   logic                     rsp_carry;
   logic [IDW-1:0]           rsp_id;
   logic [CNT_W-1:0]         grant_count;
   logic                     busy;

   int errors;
   int checks;

   adder_rr_arbiter #(
      .NUM_REQ(NUM_REQ),
      .WIDTH  (WIDTH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_sum    (rsp_sum),
      .rsp_carry  (rsp_carry),
      .rsp_id     (rsp_id),
      .grant_count(grant_count),
      .busy       (busy)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "[TB] timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      ena       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      #12;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_valid: got %b expected 0", rsp_valid);
      end
      checks++;
      if (grant_count !== 16'd0 || rsp_sum !== 8'h00 || rsp_id !== 2'd0 || rsp_carry !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_regs: got cnt=%h sum=%h id=%0d c=%b expected all zero",
                  grant_count, rsp_sum, rsp_id, rsp_carry);
      end
      checks++;
      if (req_ready !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_ready: got ready=%b busy=%b expected 0000/0", req_ready, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      step();
   endtask

   task automatic test_single();
      req_a[0*WIDTH +: WIDTH] = 8'h12;
      req_b[0*WIDTH +: WIDTH] = 8'h34;
      req_valid = 4'b0001;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL single_ready: got %b expected 0001", req_ready);
      end
      step();
      req_valid = 4'b0000;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 8'h46 || rsp_carry !== 1'b0 || rsp_id !== 2'd0 ||
          grant_count !== 16'd1 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL single_rsp: got v=%b sum=%h c=%b id=%0d cnt=%0d expected 1/46/0/0/1",
                  rsp_valid, rsp_sum, rsp_carry, rsp_id, grant_count);
      end
   endtask

   task automatic test_carry();
      // ptr is 1, so requester 2 is found after skipping 1.
      req_a[2*WIDTH +: WIDTH] = 8'hFF;
      req_b[2*WIDTH +: WIDTH] = 8'h02;
      req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL carry_ready: got %b expected 0100", req_ready);
      end
      step();
      req_valid = 4'b0000;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 8'h01 || rsp_carry !== 1'b1 || rsp_id !== 2'd2 ||
          grant_count !== 16'd2) begin
         errors++;
         $display("[TB] FAIL carry_rsp: got v=%b sum=%h c=%b id=%0d cnt=%0d expected 1/01/1/2/2",
                  rsp_valid, rsp_sum, rsp_carry, rsp_id, grant_count);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b0 || rsp_sum !== 8'h01 || rsp_carry !== 1'b1 || rsp_id !== 2'd2) begin
         errors++;
         $display("[TB] FAIL drain_hold: got v=%b sum=%h c=%b id=%0d expected 0/01/1/2",
                  rsp_valid, rsp_sum, rsp_carry, rsp_id);
      end
      // Requester 3 alone moves ptr to 0 through the wrap point.
      req_a[3*WIDTH +: WIDTH] = 8'h80;
      req_b[3*WIDTH +: WIDTH] = 8'h80;
      req_valid = 4'b1000;
      step();
      req_valid = 4'b0000;
      checks++;
      if (rsp_sum !== 8'h00 || rsp_carry !== 1'b1 || rsp_id !== 2'd3 || grant_count !== 16'd3) begin
         errors++;
         $display("[TB] FAIL wrap_req3: got sum=%h c=%b id=%0d cnt=%0d expected 00/1/3/3",
                  rsp_sum, rsp_carry, rsp_id, grant_count);
      end
   endtask

   task automatic test_fairness();
      logic [1:0] exp_id [6];
      logic [7:0] exp_sum [4];
      exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      // a_i = 16*i+1, b_i = i  ->  sum_i = 17*i+1
      exp_sum = '{8'h01, 8'h12, 8'h23, 8'h34};
      for (int i = 0; i < NUM_REQ; i++) begin
         req_a[i*WIDTH +: WIDTH] = 8'(16 * i + 1);
         req_b[i*WIDTH +: WIDTH] = 8'(i);
      end
      req_valid = 4'b1111;
      for (int n = 0; n < 6; n++) begin
         #1;
         checks++;
         if (req_ready !== (4'b0001 << exp_id[n])) begin
            errors++;
            $display("[TB] FAIL fair_ready[%0d]: got %b expected onehot(%0d)", n, req_ready, exp_id[n]);
         end
         step();
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== exp_id[n] || rsp_sum !== exp_sum[exp_id[n]] ||
             grant_count !== 16'(4 + n)) begin
            errors++;
            $display("[TB] FAIL fair_rsp[%0d]: got v=%b id=%0d sum=%h cnt=%0d expected 1/%0d/%h/%0d",
                     n, rsp_valid, rsp_id, rsp_sum, grant_count, exp_id[n], exp_sum[exp_id[n]], 4 + n);
         end
      end
   endtask

   task automatic test_backpressure();
      // Holding id 1, sum 0x12, count 9; ptr is 2.
      rsp_ready = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL bp_ready: got %b expected 0000", req_ready);
      end
      for (int n = 0; n < 3; n++) begin
         step();
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 8'h12 || grant_count !== 16'd9 ||
             req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL bp_hold[%0d]: got v=%b id=%0d sum=%h cnt=%0d rdy=%b expected 1/1/12/9/0000",
                     n, rsp_valid, rsp_id, rsp_sum, grant_count, req_ready);
         end
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL bp_release_ready: got %b expected 0100", req_ready);
      end
      step();
      req_valid = 4'b0000;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 8'h23 || grant_count !== 16'd10) begin
         errors++;
         $display("[TB] FAIL bp_release_rsp: got v=%b id=%0d sum=%h cnt=%0d expected 1/2/23/10",
                  rsp_valid, rsp_id, rsp_sum, grant_count);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_drain: got %b expected 0", rsp_valid);
      end
   endtask

   task automatic test_ena_low();
      // ptr is 3; only requester 1 valid.
      ena       = 1'b0;
      req_valid = 4'b0010;
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL ena_ready: got %b expected 0000", req_ready);
      end
      step();
      step();
      checks++;
      if (rsp_valid !== 1'b0 || grant_count !== 16'd10) begin
         errors++;
         $display("[TB] FAIL ena_nogrant: got v=%b cnt=%0d expected 0/10", rsp_valid, grant_count);
      end
      ena = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL ena_raise_ready: got %b expected 0010", req_ready);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 8'h12 || grant_count !== 16'd11) begin
         errors++;
         $display("[TB] FAIL ena_raise_rsp: got v=%b id=%0d sum=%h cnt=%0d expected 1/1/12/11",
                  rsp_valid, rsp_id, rsp_sum, grant_count);
      end
      // Pending result still drains while ena is low.
      ena       = 1'b0;
      req_valid = 4'b1111;
      step();
      checks++;
      if (rsp_valid !== 1'b0 || grant_count !== 16'd11 || rsp_id !== 2'd1) begin
         errors++;
         $display("[TB] FAIL ena_drain: got v=%b cnt=%0d id=%0d expected 0/11/1",
                  rsp_valid, grant_count, rsp_id);
      end
      ena = 1'b1;
   endtask

   task automatic test_async_reset();
      // ptr is 2; requester 2 wins.
      req_valid = 4'b0100;
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || grant_count !== 16'd12) begin
         errors++;
         $display("[TB] FAIL pre_reset: got v=%b id=%0d cnt=%0d expected 1/2/12",
                  rsp_valid, rsp_id, grant_count);
      end
      req_valid = 4'b1010;
      rsp_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || grant_count !== 16'd0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset: got v=%b cnt=%0d busy=%b expected 0/0/0",
                  rsp_valid, grant_count, busy);
      end
      @(negedge clk);
      rst       = 1'b0;
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL post_reset_ready: got %b expected 0010", req_ready);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 8'h12 || grant_count !== 16'd1) begin
         errors++;
         $display("[TB] FAIL post_reset_rsp: got v=%b id=%0d sum=%h cnt=%0d expected 1/1/12/1",
                  rsp_valid, rsp_id, rsp_sum, grant_count);
      end
      req_valid = 4'b0000;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_single();
      test_carry();
      test_fairness();
      test_backpressure();
      test_ena_low();
      test_async_reset();
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
